// File: rtl/tweet_pkg.sv
// rtl/tweet_pkg.sv - shared state encoding and constants for the tweet player
package tweet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CHECK,
        ST_START_BIT,
        ST_DATA,
        ST_STOP_BIT,
        ST_FINISH
    } state_e;

    localparam int VALID_BIT            = 15;
    localparam int DEFAULT_CLKS_PER_BIT = 5207;
    localparam int DEFAULT_MAX_CHARS    = 160;

    // The bit timer only runs while a frame is on the line.
    function automatic logic in_frame(input state_e s);
        return (s == ST_START_BIT) || (s == ST_DATA) || (s == ST_STOP_BIT);
    endfunction

endpackage

// File: rtl/tweet_player_if.sv
// rtl/tweet_player_if.sv - read port into the external character RAM
interface tweet_player_if;
    logic [7:0]  ram_addr;
    logic [15:0] ram_data;

    modport master (output ram_addr, input ram_data);
    modport slave  (input ram_addr, output ram_data);
endinterface

// File: rtl/tweet_player_baud_tick.sv
// rtl/tweet_player_baud_tick.sv - down-counter giving a one-cycle tick every CLKS_PER_BIT cycles
module baud_tick
    import tweet_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Reloading on the terminal count keeps bit boundaries drift-free across a frame.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0) && !restart_i;

endmodule

// File: rtl/tweet_player.sv
// rtl/tweet_player.sv - plays valid RAM entries out as 8N1 serial frames
module tweet_player
    import tweet_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int MAX_CHARS    = DEFAULT_MAX_CHARS
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  ram_addr,
    input  logic [15:0] ram_data,
    output logic        serial_out,
    output logic        busy,
    output logic        done,
    output logic [7:0]  char_count
);
    localparam logic [7:0] LAST_ADDR = 8'(MAX_CHARS);

    state_e     state_q;
    logic [7:0] ram_addr_q;
    logic [7:0] char_count_q;
    logic [7:0] shift_q;
    logic [2:0] bit_idx_q;
    logic       serial_q;
    logic       busy_q;
    logic       done_q;
    logic       tick;
    logic       ram_data_unused;

    assign ram_data_unused = ^ram_data[14:8];

    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_tick (
        .clk_i     (sysclk),
        .rst_i     (reset),
        .restart_i (!in_frame(state_q)),
        .tick_o    (tick)
    );

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ram_addr_q   <= '0;
            char_count_q <= '0;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            serial_q     <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ram_addr_q   <= '0;
                        char_count_q <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_FETCH;
                    end
                end
                ST_FETCH: state_q <= ST_CHECK;
                ST_CHECK: begin
                    // done is raised on entry so it is high for exactly the FINISH cycle.
                    if (!ram_data[VALID_BIT] || (ram_addr_q == LAST_ADDR)) begin
                        done_q  <= 1'b1;
                        state_q <= ST_FINISH;
                    end else begin
                        shift_q  <= ram_data[7:0];
                        serial_q <= 1'b0;
                        state_q  <= ST_START_BIT;
                    end
                end
                ST_START_BIT: begin
                    if (tick) begin
                        serial_q  <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx_q == 3'd7) begin
                            serial_q <= 1'b1;
                            state_q  <= ST_STOP_BIT;
                        end else begin
                            serial_q  <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                ST_STOP_BIT: begin
                    if (tick) begin
                        ram_addr_q   <= ram_addr_q + 8'd1;
                        char_count_q <= char_count_q + 8'd1;
                        state_q      <= ST_FETCH;
                    end
                end
                ST_FINISH: begin
                    busy_q     <= 1'b0;
                    ram_addr_q <= '0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ram_addr   = ram_addr_q;
    assign char_count = char_count_q;
    assign serial_out = serial_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_tweet_player.sv
// tb/tb_tweet_player.sv - directed self-checking bench for tweet_player
module tb_tweet_player;
    localparam int CPB  = 4;
    localparam int MAXC = 4;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       start;
    logic       serial_out;
    logic       busy;
    logic       done;
    logic [7:0] char_count;

    tweet_player_if ram_bus ();

    logic [15:0] ram [0:255];

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) ram_bus.ram_data <= ram[ram_bus.ram_addr];

    tweet_player #(.CLKS_PER_BIT(CPB), .MAX_CHARS(MAXC)) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .start      (start),
        .ram_addr   (ram_bus.ram_addr),
        .ram_data   (ram_bus.ram_data),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done),
        .char_count (char_count)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    logic tr [0:511];
    int   last_c;
    int   done_cyc;
    int   n_done;
    int   max_addr;
    int   starts [0:7];
    int   nf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    endtask

    task automatic pulse_start();
        @(negedge sysclk);
        start = 1'b1;
    endtask

    // Samples one cycle per negedge; cycle 1 is the first cycle after start was accepted.
    task automatic capture(input int budget, input int start_at);
        done_cyc = -1;
        n_done   = 0;
        max_addr = 0;
        last_c   = 0;
        for (int i = 0; i < 512; i++) tr[i] = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge sysclk);
            tr[c]  = serial_out;
            last_c = c;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (int'(ram_bus.ram_addr) > max_addr) max_addr = int'(ram_bus.ram_addr);
            start = (c == start_at);
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
        start = 1'b0;
    endtask

    task automatic find_frames();
        int c;
        nf = 0;
        c  = 1;
        while (c <= last_c) begin
            if (tr[c] === 1'b0 && nf < 8) begin
                starts[nf] = c;
                nf++;
                c += 10 * CPB;
            end else begin
                c++;
            end
        end
    endtask

    task automatic check_frame(input string tag, input int s, input logic [7:0] exp_byte);
        logic [9:0] expv;
        logic [7:0] got;
        int bad;
        expv = {1'b1, exp_byte, 1'b0};
        bad  = 0;
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < CPB; j++)
                if (tr[s + k * CPB + j] !== expv[k]) bad++;
        for (int i = 0; i < 8; i++) got[i] = tr[s + (i + 1) * CPB + CPB / 2];
        check({tag, "_byte"}, got, exp_byte);
        check({tag, "_bad_samples"}, bad, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        clear_ram();
        repeat (3) @(negedge sysclk);
        check("rst_serial", serial_out, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", ram_bus.ram_addr, 0);
        check("rst_count", char_count, 0);
        reset = 1'b0;

        // 'H' then terminator
        ram[0] = 16'h8048;
        pulse_start();
        capture(200, 0);
        find_frames();
        check("h_frames", nf, 1);
        check("h_start_cyc", starts[0], 3);
        check_frame("h", starts[0], 8'h48);
        check("h_done_cyc", done_cyc, 45);
        check("h_done_pulses", n_done, 1);
        check("h_count", char_count, 1);
        check("h_busy_after", busy, 0);
        check("h_addr_after", ram_bus.ram_addr, 0);

        // empty buffer
        clear_ram();
        pulse_start();
        capture(20, 0);
        find_frames();
        check("empty_done_cyc", done_cyc, 3);
        check("empty_frames", nf, 0);
        check("empty_count", char_count, 0);

        // full buffer, then again with a start pulse during frame 2
        for (int i = 0; i < 6; i++) ram[i] = 16'h8030 + 16'(i);
        for (int pass = 0; pass < 2; pass++) begin
            pulse_start();
            capture(400, (pass == 0) ? 0 : 60);
            find_frames();
            check("full_frames", nf, 4);
            for (int k = 0; k < 4 && k < nf; k++) begin
                check("full_start_cyc", starts[k], 3 + 42 * k);
                check_frame("full", starts[k], 8'h30 + 8'(k));
            end
            check("full_done_cyc", done_cyc, 171);
            check("full_max_addr", max_addr, 4);
            check("full_count", char_count, 4);
        end

        // reset and start together
        clear_ram();
        ram[0] = 16'h8041;
        ram[1] = 16'h8042;
        @(negedge sysclk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge sysclk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_busy", busy, 0);

        // reset in the middle of data bit 3 of 'A'
        pulse_start();
        for (int c = 1; c <= 20; c++) begin
            @(negedge sysclk);
            start = 1'b0;
        end
        check("mid_line_low", serial_out, 0);
        reset = 1'b1;
        @(negedge sysclk);
        reset = 1'b0;
        check("mid_rst_serial", serial_out, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", ram_bus.ram_addr, 0);
        check("mid_rst_count", char_count, 0);
        capture(30, 0);
        find_frames();
        check("mid_quiet_frames", nf, 0);
        check("mid_no_done", n_done, 0);

        // replay from address 0: 'A','B'
        pulse_start();
        capture(200, 0);
        find_frames();
        check("ab_frames", nf, 2);
        check("ab_start0", starts[0], 3);
        check_frame("ab0", starts[0], 8'h41);
        check_frame("ab1", starts[1], 8'h42);
        check("ab_gap", starts[1] - (starts[0] + 10 * CPB), 2);
        check("ab_done_cyc", done_cyc, 87);
        check("ab_count", char_count, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
